// File: rtl/mem_arbiter_pkg.sv
// Shared bus typedefs plus arbiter state/owner enums for the ibus/dbus to memory-port arbiter.
// Pure types and one conversion helper; no timing or flow control of its own.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic        data_ok;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic [63:0] data;
    logic        data_ok;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } grant_owner_t;

  // A fetch is always a read of one 32-bit word on the 64-bit memory port.
  function automatic dbus_req_t ibus_to_dbus(input ibus_req_t r);
    dbus_req_t d;
    d        = '0;
    d.valid  = r.valid;
    d.addr   = r.addr;
    d.size   = MSIZE4;
    return d;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter of fetch (ibus) and data (dbus) onto one memory port; grant registered, 1-cycle latency.
// Requesters wait while the port is busy; responses pass through combinationally; one IDLE cycle between grants.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output dbus_req_t  mreq,
  input  dbus_resp_t mresp,
  output logic       busy
);

  arb_state_t   state, state_nxt;
  grant_owner_t last_grant;
  dbus_req_t    req_q;
  logic         grant_i, grant_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= OWNER_I;
      req_q      <= '0;
    end else begin
      state <= state_nxt;
      if (grant_d) begin
        req_q <= dreq;
      end else if (grant_i) begin
        req_q <= ibus_to_dbus(ireq);
      end
      if (state == IGRANT && mresp.data_ok) begin
        last_grant <= OWNER_I;
      end else if (state == DGRANT && mresp.data_ok) begin
        last_grant <= OWNER_D;
      end
    end
  end

  // On a tie the requester not served last wins, which bounds any wait to one transaction.
  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        if (dreq.valid && (!ireq.valid || last_grant == OWNER_I)) begin
          grant_d   = 1'b1;
          state_nxt = DGRANT;
        end else if (ireq.valid) begin
          grant_i   = 1'b1;
          state_nxt = IGRANT;
        end
      end
      IGRANT, DGRANT: begin
        if (mresp.data_ok) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mreq          = req_q;
    mreq.valid    = (state != IDLE);
    iresp.data    = req_q.addr[2] ? mresp.data[63:32] : mresp.data[31:0];
    iresp.data_ok = (state == IGRANT) && mresp.data_ok;
    dresp.data    = mresp.data;
    dresp.data_ok = (state == DGRANT) && mresp.data_ok;
    busy          = (state != IDLE);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: hand-computed grants, latched fields and response routing.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  dbus_req_t  mreq;
  dbus_resp_t mresp;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  int icount = 0;
  int dcount = 0;
  int ic0, dc0;

  dbus_req_t d_st;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .ireq  (ireq),
    .iresp (iresp),
    .dreq  (dreq),
    .dresp (dresp),
    .mreq  (mreq),
    .mresp (mresp),
    .busy  (busy)
  );

  always @(negedge clk) begin
    if (iresp.data_ok) icount++;
    if (dresp.data_ok) dcount++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Waits lat cycles, then returns read data with data_ok and stops at the negedge of that cycle.
  task automatic mem_reply(input int lat, input logic [63:0] rd);
    repeat (lat) cyc();
    mresp.data    = rd;
    mresp.data_ok = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ireq  = '0;
    dreq  = '0;
    mresp = '0;
    d_st  = '{valid: 1'b1, addr: 32'h10, size: MSIZE8, strobe: 8'hff, data: 64'hDEAD_BEEF_0123_4567};

    // reset state, with a stray data_ok present
    mresp.data_ok = 1'b1;
    @(negedge clk);
    check("rst_busy",   64'(busy),          64'd0);
    check("rst_mvalid", 64'(mreq.valid),    64'd0);
    check("rst_maddr",  64'(mreq.addr),     64'd0);
    check("rst_iok",    64'(iresp.data_ok), 64'd0);
    check("rst_dok",    64'(dresp.data_ok), 64'd0);
    mresp = '0;
    cyc();
    reset = 1'b1;

    // tie in first cycle after reset: data wins, then fetch after one idle cycle
    ireq = '{valid: 1'b1, addr: 32'h8000_0004};
    dreq = d_st;
    @(negedge clk);
    check("t1_idle_mvalid", 64'(mreq.valid), 64'd0);
    cyc();
    @(negedge clk);
    check("t1_d_mvalid", 64'(mreq.valid),  64'd1);
    check("t1_d_busy",   64'(busy),        64'd1);
    check("t1_d_addr",   64'(mreq.addr),   64'h10);
    check("t1_d_size",   64'(mreq.size),   64'(MSIZE8));
    check("t1_d_strobe", 64'(mreq.strobe), 64'hff);
    check("t1_d_data",   mreq.data,        64'hDEAD_BEEF_0123_4567);
    mem_reply(1, 64'hAAAA_BBBB_CCCC_DDDD);
    check("t1_d_dok",    64'(dresp.data_ok), 64'd1);
    check("t1_d_ddata",  dresp.data,         64'hAAAA_BBBB_CCCC_DDDD);
    check("t1_d_iok",    64'(iresp.data_ok), 64'd0);
    check("t1_d_stable", 64'(mreq.addr),     64'h10);
    cyc();
    mresp.data_ok = 1'b0;
    dreq.valid    = 1'b0;
    @(negedge clk);
    check("t1_gap_mvalid", 64'(mreq.valid), 64'd0);
    check("t1_gap_busy",   64'(busy),       64'd0);
    cyc();
    ic0 = icount;
    @(negedge clk);
    check("t1_i_mvalid", 64'(mreq.valid),  64'd1);
    check("t1_i_addr",   64'(mreq.addr),   64'h8000_0004);
    check("t1_i_size",   64'(mreq.size),   64'(MSIZE4));
    check("t1_i_strobe", 64'(mreq.strobe), 64'h0);
    check("t1_i_data",   mreq.data,        64'h0);
    mem_reply(3, 64'h1111_2222_3333_4444);
    check("t1_i_iok",   64'(iresp.data_ok), 64'd1);
    check("t1_i_idata", 64'(iresp.data),    64'h1111_2222);
    check("t1_i_dok",   64'(dresp.data_ok), 64'd0);
    cyc();
    mresp.data_ok = 1'b0;
    check("t1_i_pulses", 64'(icount - ic0), 64'd1);

    // both held valid: grants alternate D, I, D, I
    ireq = '{valid: 1'b1, addr: 32'h8};
    dreq = d_st;
    for (int k = 0; k < 4; k++) begin
      logic        exp_d;
      logic [63:0] rd;
      exp_d = (k % 2 == 0);
      rd    = 64'h0102_0304_0506_0700 + 64'(k);
      cyc();
      @(negedge clk);
      check("rr_mvalid", 64'(mreq.valid), 64'd1);
      check("rr_owner",  64'(mreq.addr),  exp_d ? 64'h10 : 64'h8);
      mem_reply(1, rd);
      check("rr_dok", 64'(dresp.data_ok), 64'(exp_d));
      check("rr_iok", 64'(iresp.data_ok), 64'(!exp_d));
      if (exp_d) check("rr_ddata", dresp.data, rd);
      else       check("rr_idata", 64'(iresp.data), {32'h0, rd[31:0]});
      cyc();
      mresp.data_ok = 1'b0;
      @(negedge clk);
      check("rr_gap_mvalid", 64'(mreq.valid), 64'd0);
    end
    ireq.valid = 1'b0;
    dreq.valid = 1'b0;

    // data_ok while idle is ignored
    cyc();
    mresp.data_ok = 1'b1;
    @(negedge clk);
    check("idle_iok",  64'(iresp.data_ok), 64'd0);
    check("idle_dok",  64'(dresp.data_ok), 64'd0);
    check("idle_busy", 64'(busy),          64'd0);
    cyc();
    mresp.data_ok = 1'b0;
    @(negedge clk);
    check("idle_busy2", 64'(busy), 64'd0);

    // fetch valid dropped after grant: request stays latched until data_ok
    cyc();
    ireq = '{valid: 1'b1, addr: 32'h8000_0004};
    ic0  = icount;
    cyc();
    ireq = '{valid: 1'b0, addr: 32'h0000_1234};
    @(negedge clk);
    check("drop_mvalid", 64'(mreq.valid), 64'd1);
    check("drop_addr",   64'(mreq.addr),  64'h8000_0004);
    cyc();
    @(negedge clk);
    check("drop_addr2",  64'(mreq.addr),  64'h8000_0004);
    mem_reply(1, 64'h5555_6666_7777_8888);
    check("drop_iok",   64'(iresp.data_ok), 64'd1);
    check("drop_idata", 64'(iresp.data),    64'h5555_6666);
    cyc();
    mresp.data_ok = 1'b0;
    check("drop_pulses", 64'(icount - ic0), 64'd1);
    @(negedge clk);
    check("drop_idle", 64'(busy), 64'd0);
    cyc();
    @(negedge clk);
    check("drop_noregrant", 64'(busy), 64'd0);

    // reset two cycles into a store, stray data_ok after release
    cyc();
    dreq = '{valid: 1'b1, addr: 32'h40, size: MSIZE8, strobe: 8'hff, data: 64'h0F0F_0F0F_0F0F_0F0F};
    cyc();
    @(negedge clk);
    check("rst2_busy_pre", 64'(busy), 64'd1);
    cyc();
    cyc();
    #2;
    reset      = 1'b0;
    dreq.valid = 1'b0;
    #1;
    check("rst2_mvalid", 64'(mreq.valid), 64'd0);
    check("rst2_busy",   64'(busy),       64'd0);
    check("rst2_maddr",  64'(mreq.addr),  64'd0);
    @(negedge clk);
    cyc();
    reset = 1'b1;
    dc0   = dcount;
    cyc();
    mresp.data    = 64'hCAFE_CAFE_CAFE_CAFE;
    mresp.data_ok = 1'b1;
    @(negedge clk);
    check("rst2_dok",    64'(dresp.data_ok), 64'd0);
    check("rst2_busy2",  64'(busy),          64'd0);
    check("rst2_mvalid2", 64'(mreq.valid),   64'd0);
    cyc();
    mresp.data_ok = 1'b0;
    check("rst2_dpulses", 64'(dcount - dc0), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
